bram_fifo_ctrl: RTL and testbench

FIFO controller that sits directly upstream of the dual-port BRAM primitive. It drives the BRAM write and read ports. It turns the BRAM's fixed 1-cycle registered read into a valid/ready output stream with full throughput. It is used wherever a deep buffer must be built from block RAM rather than registers (e.g. memory-read staging ahead of compute pipelines).

---
 rtl/pipearch_common.sv | 8 +
 rtl/bram_fifo_skid.sv | 36 +++
 rtl/bram_fifo_ctrl.sv | 70 +++++++
 tb/tb_bram_fifo_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipearch_common.sv
// pipearch_common: shared FIFO sizing helper and word type
package pipearch_common;
  localparam int WORD_W = 8;
  typedef logic [WORD_W-1:0] word_t;
  function automatic int fifo_cnt_w(input int log2_depth);
    return log2_depth + 1;
  endfunction
endpackage

// File: rtl/bram_fifo_skid.sv
// bram_fifo_skid: 2-entry output buffer that absorbs BRAM read returns
// Ports: clk, reset (sync, active-high); cap/cap_data append a word;
// out_valid/out_ready/out_data present the head; cnt holds 0..2.
module bram_fifo_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cap,
  input  logic [WIDTH-1:0] cap_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       cnt
);
  logic [WIDTH-1:0] b0, b1;
  logic pop;
  assign out_valid = cnt != 2'd0;
  assign out_data = b0;
  assign pop = out_valid && out_ready;
  // A capture always lands in the first free slot after any pop has shifted.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 2'd0;
    end else begin
      cnt <= cnt + 2'(cap) - 2'(pop);
      if (pop) begin
        b0 <= cnt == 2'd2 ? b1 : cap_data;
        b1 <= cap_data;
      end else if (cap) begin
        if (cnt == 2'd0) b0 <= cap_data;
        else b1 <= cap_data;
      end
    end
  end
endmodule

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: BRAM-backed FIFO controller with valid/ready output stream
// Ports: clk, reset (sync, active-high); in_push/in_data/in_full write side;
// out_valid/out_ready/out_data read side; count, sticky overflow;
// mem_we/mem_waddr/mem_wdata, mem_re/mem_raddr to BRAM; mem_rvalid/mem_rdata from BRAM.
module bram_fifo_ctrl
  import pipearch_common::*;
#(
  parameter int WIDTH = 8,
  parameter int LOG2_DEPTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_push,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_full,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [LOG2_DEPTH+1:0] count,
  output logic                  overflow,
  output logic                  mem_we,
  output logic [LOG2_DEPTH-1:0] mem_waddr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  mem_re,
  output logic [LOG2_DEPTH-1:0] mem_raddr,
  input  logic                  mem_rvalid,
  input  logic [WIDTH-1:0]      mem_rdata
);
  localparam int CW = fifo_cnt_w(LOG2_DEPTH);
  localparam int OW = LOG2_DEPTH + 2;
  logic [LOG2_DEPTH-1:0] wptr, rptr;
  logic [CW-1:0] mem_cnt;
  logic inflight, pop;
  logic [1:0] obuf_cnt;
  assign in_full = mem_cnt == CW'(2 ** LOG2_DEPTH);
  assign mem_we = in_push && !in_full;
  assign mem_waddr = wptr;
  assign mem_wdata = in_data;
  assign pop = out_valid && out_ready;
  // Issue a read only if the skid buffer is guaranteed a free slot when it returns.
  assign mem_re = (mem_cnt != '0) && (3'(obuf_cnt) + 3'(inflight) < 3'(pop) + 3'd2);
  assign mem_raddr = rptr;
  assign count = OW'(mem_cnt) + OW'(inflight) + OW'(obuf_cnt);
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      mem_cnt <= '0;
      inflight <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wptr <= wptr + LOG2_DEPTH'(mem_we);
      rptr <= rptr + LOG2_DEPTH'(mem_re);
      mem_cnt <= mem_cnt + CW'(mem_we) - CW'(mem_re);
      inflight <= mem_re;
      overflow <= overflow || (in_push && in_full);
    end
  end
  // A return arriving without a matching issue (e.g. just after reset) is dropped.
  bram_fifo_skid #(.WIDTH(WIDTH)) u_skid (
    .clk(clk),
    .reset(reset),
    .cap(inflight && mem_rvalid),
    .cap_data(mem_rdata),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .cnt(obuf_cnt)
  );
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl: self-checking bench for bram_fifo_ctrl with a BRAM model
module tb_bram_fifo_ctrl;
  localparam int W = 8;
  localparam int L = 5;
  logic clk = 1'b0, reset = 1'b1, in_push = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_full, out_valid, overflow, mem_we, mem_re;
  logic [W-1:0] out_data, mem_wdata;
  logic [L+1:0] count;
  logic [L-1:0] mem_waddr, mem_raddr;
  logic mem_rvalid = 1'b0;
  logic [W-1:0] mem_rdata = '0;
  logic [W-1:0] mem [2**L];
  int pass_cnt = 0, chk_cnt = 0;

  always #5 clk = ~clk;

  // BRAM with 1-cycle registered read; not reset, like the real primitive.
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_rvalid <= mem_re;
    if (mem_re) mem_rdata <= mem[mem_raddr];
  end

  bram_fifo_ctrl #(.WIDTH(W), .LOG2_DEPTH(L)) dut (
    .clk(clk), .reset(reset), .in_push(in_push), .in_data(in_data), .in_full(in_full),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count),
    .overflow(overflow), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic cyc(input logic p, input logic [W-1:0] d, input logic r, input logic rs = 1'b0);
    @(negedge clk);
    in_push = p;
    in_data = d;
    out_ready = r;
    reset = rs;
    #1;
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
  endtask

  typedef struct {
    logic push; logic [W-1:0] data; logic ready;
    logic valid; logic [W-1:0] odata; int cnt; logic we; logic re;
  } vec_t;
  vec_t tv[5];

  initial begin
    byte unsigned q[$];
    int got;
    logic hold;
    logic [W-1:0] held, seq;
    logic p, r;
    tv[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0};
    tv[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b1};
    tv[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0};
    tv[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1, 1'b0, 1'b0};
    tv[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0};

    do_reset();
    cyc(0, 0, 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_full", 32'(in_full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_re", 32'(mem_re), 0);
    chk("rst_ovf", 32'(overflow), 0);

    for (int i = 0; i < 5; i++) begin
      cyc(tv[i].push, tv[i].data, tv[i].ready);
      chk($sformatf("tv%0d_valid", i), 32'(out_valid), 32'(tv[i].valid));
      if (tv[i].valid) chk($sformatf("tv%0d_data", i), 32'(out_data), 32'(tv[i].odata));
      chk($sformatf("tv%0d_count", i), 32'(count), 32'(tv[i].cnt));
      chk($sformatf("tv%0d_we", i), 32'(mem_we), 32'(tv[i].we));
      chk($sformatf("tv%0d_re", i), 32'(mem_re), 32'(tv[i].re));
    end

    do_reset();
    for (int i = 0; i < 35; i++) begin
      cyc(1, W'(i), 0);
      chk($sformatf("fill%0d_full", i), 32'(in_full), i == 34 ? 1 : 0);
      chk($sformatf("fill%0d_we", i), 32'(mem_we), i == 34 ? 0 : 1);
    end
    cyc(0, 0, 0);
    chk("fill_ovf", 32'(overflow), 1);
    chk("fill_count", 32'(count), 34);
    chk("fill_head", 32'(out_data), 0);
    got = 0;
    for (int k = 0; k < 60; k++) begin
      cyc(0, 0, 1);
      if (out_valid) begin
        chk($sformatf("drain%0d", got), 32'(out_data), 32'(got));
        got++;
      end
    end
    chk("drain_total", 32'(got), 34);
    chk("drain_count", 32'(count), 0);

    do_reset();
    for (int c = 0; c < 104; c++) begin
      cyc(c < 100, W'(c), 1);
      if (c >= 3 && c < 103) begin
        chk($sformatf("stream%0d_valid", c), 32'(out_valid), 1);
        chk($sformatf("stream%0d_data", c), 32'(out_data), 32'(c - 3));
      end else chk($sformatf("stream%0d_valid", c), 32'(out_valid), 0);
    end
    chk("stream_ovf", 32'(overflow), 0);
    chk("stream_count", 32'(count), 0);

    do_reset();
    q.delete();
    hold = 0;
    held = '0;
    seq = '0;
    for (int c = 0; c < 620; c++) begin
      p = c < 500;
      r = c < 600 ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc(p, seq, r);
      chk("rnd_count", 32'(count), 32'(q.size()));
      if (q.size() == 0) chk("rnd_empty", 32'(out_valid), 0);
      if (out_valid && q.size() != 0) chk("rnd_data", 32'(out_data), 32'(q[0]));
      if (hold) chk("rnd_hold", 32'(out_data), 32'(held));
      if (q.size() < 32) chk("rnd_notfull", 32'(in_full), 0);
      if (q.size() == 34) chk("rnd_full", 32'(in_full), 1);
      hold = out_valid && !r;
      held = out_data;
      if (out_valid && r && q.size() != 0) void'(q.pop_front());
      if (p && !in_full) q.push_back(seq);
      seq++;
    end
    cyc(0, 0, 1);
    chk("rnd_final_count", 32'(count), 32'(q.size()));
    chk("rnd_final_empty", 32'(q.size()), 0);

    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, W'(8'h10 + i), 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("mid_count10", 32'(count), 10);
    cyc(0, 0, 1);
    chk("mid_re", 32'(mem_re), 1);
    cyc(0, 0, 1, 1);
    cyc(1, 8'h3C, 1);
    chk("mid_stale_rvalid", 32'(mem_rvalid), 1);
    chk("mid_count0", 32'(count), 0);
    chk("mid_valid0", 32'(out_valid), 0);
    cyc(0, 0, 1);
    chk("mid_c1_valid", 32'(out_valid), 0);
    cyc(0, 0, 1);
    chk("mid_c2_valid", 32'(out_valid), 0);
    cyc(0, 0, 1);
    chk("mid_c3_valid", 32'(out_valid), 1);
    chk("mid_c3_data", 32'(out_data), 32'h3C);
    chk("mid_c3_count", 32'(count), 1);
    cyc(0, 0, 1);
    chk("mid_c4_valid", 32'(out_valid), 0);
    chk("mid_c4_count", 32'(count), 0);

    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, W'(i), 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("ss_count_init", 32'(count), 5);
    for (int i = 0; i < 10; i++) begin
      cyc(1, W'(5 + i), 1);
      chk($sformatf("ss%0d_count", i), 32'(count), 5);
      chk($sformatf("ss%0d_full", i), 32'(in_full), 0);
      chk($sformatf("ss%0d_data", i), 32'(out_data), 32'(i));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
